// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: funnels register-file write requests from NREQ requesters
// onto the single register-file write port through one registered stage.
// Round-robin arbitration, optional core (requester 0) priority bounded by a
// starvation counter, a hardwired zero register at address 0, and per-address
// write protection that reserves selected addresses for the core.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_stall      blocks all grants while high
//   req_valid     per-requester write request
//   req_ready     per-requester accept (combinational, one-hot or zero)
//   req_addr      packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data      packed data, requester i at [i*DATA_W +: DATA_W]
//   write_en      register-file write strobe (registered)
//   wrData        register-file write address (registered, holds)
//   DataIn        register-file write data (registered, holds)
//   grant_id      requester behind the current write_en
//   err_pulse     one-cycle protected-address violation pulse
//   err_id        requester that caused the violation
module reg_write_arbiter #(
    parameter int unsigned NREQ          = 3,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned CORE_PRIORITY = 1,
    parameter int unsigned STARVE_LIMIT  = 8,
    parameter logic [(2**ADDR_W)-1:0] PROT_MASK = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_stall,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic                     write_en,
    output logic [ADDR_W-1:0]        wrData,
    output logic [DATA_W-1:0]        DataIn,
    output logic [1:0]               grant_id,
    output logic                     err_pulse,
    output logic [1:0]               err_id
);

    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [ID_W-1:0]   rr_last;
    logic [CNT_W-1:0]  starve_cnt;

    logic              others_valid;
    logic              starved;
    logic [NREQ-1:0]   elig;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   rr_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_zero;
    logic              sel_prot;

    // Grant selection: core first (unless starving others), else round-robin
    // starting one past the last winner.
    always_comb begin : arb_comb
        others_valid = |req_valid[NREQ-1:1];
        starved      = (starve_cnt == CNT_W'(STARVE_LIMIT)) && others_valid;
        elig         = req_valid;
        grant_any    = 1'b0;
        grant_idx    = '0;
        rr_idx       = '0;
        // A starving core steps aside so round-robin covers 1..NREQ-1 only.
        if (CORE_PRIORITY != 0 && starved) begin
            elig[0] = 1'b0;
        end
        if (!rst && !wr_stall) begin
            if (CORE_PRIORITY != 0 && elig[0]) begin
                grant_any = 1'b1;
                grant_idx = '0;
            end else begin
                for (int unsigned k = 1; k <= NREQ; k++) begin
                    rr_idx = ID_W'((32'(rr_last) + k) % NREQ);
                    if (!grant_any && elig[rr_idx]) begin
                        grant_any = 1'b1;
                        grant_idx = rr_idx;
                    end
                end
            end
        end
    end

    // One-hot accept for the winner.
    always_comb begin : ready_comb
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Winner's address/data mux and write classification.
    always_comb begin : sel_comb
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        sel_zero = (sel_addr == '0);
        sel_prot = PROT_MASK[sel_addr] && (grant_idx != '0);
    end

    // Round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= ID_W'(NREQ - 1);
        end else if (grant_any) begin
            rr_last <= grant_idx;
        end
    end

    // Consecutive core grants while someone else waits; frozen during stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!wr_stall) begin
            if (!others_valid) begin
                starve_cnt <= '0;
            end else if (grant_any && grant_idx == '0) begin
                if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else if (grant_any) begin
                starve_cnt <= '0;
            end
        end
    end

    // Registered write port; address 0 and protected writes are swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en  <= 1'b0;
            wrData    <= '0;
            DataIn    <= '0;
            grant_id  <= '0;
            err_pulse <= 1'b0;
            err_id    <= '0;
        end else begin
            write_en  <= 1'b0;
            err_pulse <= 1'b0;
            if (grant_any && !sel_zero) begin
                if (sel_prot) begin
                    err_pulse <= 1'b1;
                    err_id    <= grant_idx;
                end else begin
                    write_en <= 1'b1;
                    wrData   <= sel_addr;
                    DataIn   <= sel_data;
                    grant_id <= grant_idx;
                end
            end
        end
    end

endmodule
